// File: rtl/openddr_dfi_phy_responder.sv
// openddr_dfi_phy_responder
// DFI PHY/DRAM-side responder for the OpenDDR controller. Decodes phase-p0
// commands through a two-state rank FSM, keeps a small word array updated by
// masked write data and returns read data a fixed RDLAT cycles after each RD.
// Sticky error flags report protocol and write-data timing violations.
//
// Write-data timing: a WR accepted on edge T is due on edge T+WRLAT, i.e.
// dfi_wrdata_en_0_p0 must be high in the cycle that ends with that edge.
// There is no backpressure: every input is sampled on each rising edge of mck
// and the responder never stalls the controller.
module openddr_dfi_phy_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 16,
  parameter int WRLAT      = 2,
  parameter int RDLAT      = 4,
  parameter int WQ_DEPTH   = 4
) (
  input  logic                    mck,
  input  logic                    mc_rst,
  input  logic                    dfi_reset_n,
  input  logic [1:0]              dfi_cs_0_p0,
  input  logic [6:0]              dfi_address_0_p0,
  input  logic [DATA_WIDTH-1:0]   dfi_wrdata_0_p0,
  input  logic [DATA_WIDTH/8-1:0] dfi_wrdata_mask_0_p0,
  input  logic                    dfi_wrdata_en_0_p0,
  output logic [DATA_WIDTH-1:0]   dfi_rddata_0_p0,
  output logic                    dfi_rddata_valid_0_p0,
  output logic                    rank_active,
  output logic                    err_proto,
  output logic                    err_wdata,
  output logic [15:0]             rd_count,
  output logic [15:0]             wr_count
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int NW = 1 << IW;
  localparam int CW = $clog2(WRLAT + 1);
  localparam int QW = $clog2(WQ_DEPTH + 1);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ACT = 3'b001;
  localparam logic [2:0] OP_WR  = 3'b010;
  localparam logic [2:0] OP_RD  = 3'b011;
  localparam logic [2:0] OP_PRE = 3'b100;
  localparam logic [2:0] OP_REF = 3'b101;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Either reset source clears control state; only mc_rst clears the array.
  logic w_rst;
  assign w_rst = mc_rst | ~dfi_reset_n;

  logic          w_cmd_vld;
  logic [2:0]    w_op;
  logic [IW-1:0] w_idx;
  assign w_cmd_vld = dfi_cs_0_p0[0];
  assign w_op      = dfi_address_0_p0[6:4];
  assign w_idx     = dfi_address_0_p0[IW-1:0];

  // cs bit1 and the index bits above IW carry no meaning here.
  logic w_unused;
  assign w_unused = ^{dfi_cs_0_p0[1], dfi_address_0_p0[3:0]};

  logic w_rd_acc;
  logic w_wr_req;
  logic w_proto_bad;

  // Rank state register.
  always_ff @(posedge mck) begin
    if (w_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Command decode against the current rank state.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_acc    = 1'b0;
    w_wr_req    = 1'b0;
    w_proto_bad = 1'b0;
    if (w_cmd_vld) begin
      case (w_op)
        OP_NOP: ;
        OP_ACT: if (r_state == ST_IDLE) w_state_nxt = ST_ACTIVE;
                else                    w_proto_bad = 1'b1;
        OP_WR:  if (r_state == ST_ACTIVE) w_wr_req = 1'b1;
                else                      w_proto_bad = 1'b1;
        OP_RD:  if (r_state == ST_ACTIVE) w_rd_acc = 1'b1;
                else                      w_proto_bad = 1'b1;
        OP_PRE: w_state_nxt = ST_IDLE;
        OP_REF: if (r_state == ST_ACTIVE) w_proto_bad = 1'b1;
        default: w_proto_bad = 1'b1;
      endcase
    end
  end

  // Outstanding-write queue: entry 0 is the oldest. The countdown is loaded
  // with WRLAT and decremented on every later edge (saturating at 0), so an
  // on-time wrdata_en finds the head countdown at exactly 1 on its edge.
  logic [IW-1:0] r_wq_idx     [WQ_DEPTH];
  logic [CW-1:0] r_wq_cnt     [WQ_DEPTH];
  logic [QW-1:0] r_wq_num;
  logic [IW-1:0] w_wq_idx_nxt [WQ_DEPTH];
  logic [CW-1:0] w_wq_cnt_nxt [WQ_DEPTH];
  logic [CW-1:0] w_cnt_dec    [WQ_DEPTH];
  logic [QW-1:0] w_num_after_pop;
  logic [QW-1:0] w_wq_num_nxt;
  logic          w_pop;
  logic          w_wen_empty;
  logic          w_wr_off_time;
  logic          w_wq_full;
  logic          w_wr_acc;
  logic          w_wr_drop;

  // Queue pop/push and countdown update.
  always_comb begin
    w_pop           = dfi_wrdata_en_0_p0 && (r_wq_num != '0) && !w_rst;
    w_wen_empty     = dfi_wrdata_en_0_p0 && (r_wq_num == '0);
    w_wr_off_time   = w_pop && (r_wq_cnt[0] != CW'(1));
    w_wq_full       = (r_wq_num == QW'(WQ_DEPTH)) && !w_pop;
    w_wr_acc        = w_wr_req && !w_wq_full;
    w_wr_drop       = w_wr_req && w_wq_full;
    w_num_after_pop = r_wq_num - QW'(w_pop);
    w_wq_num_nxt    = w_num_after_pop + QW'(w_wr_acc);
    for (int i = 0; i < WQ_DEPTH; i++) begin
      w_cnt_dec[i]    = (r_wq_cnt[i] == '0) ? '0 : r_wq_cnt[i] - CW'(1);
      w_wq_idx_nxt[i] = r_wq_idx[i];
      w_wq_cnt_nxt[i] = w_cnt_dec[i];
    end
    if (w_pop) begin
      for (int i = 0; i < WQ_DEPTH - 1; i++) begin
        w_wq_idx_nxt[i] = r_wq_idx[i+1];
        w_wq_cnt_nxt[i] = w_cnt_dec[i+1];
      end
    end
    for (int i = 0; i < WQ_DEPTH; i++) begin
      if (w_wr_acc && (w_num_after_pop == QW'(i))) begin
        w_wq_idx_nxt[i] = w_idx;
        w_wq_cnt_nxt[i] = CW'(WRLAT);
      end
    end
  end

  // Write-queue registers.
  always_ff @(posedge mck) begin
    if (w_rst) begin
      r_wq_num <= '0;
      for (int i = 0; i < WQ_DEPTH; i++) begin
        r_wq_idx[i] <= '0;
        r_wq_cnt[i] <= '0;
      end
    end else begin
      r_wq_num <= w_wq_num_nxt;
      for (int i = 0; i < WQ_DEPTH; i++) begin
        r_wq_idx[i] <= w_wq_idx_nxt[i];
        r_wq_cnt[i] <= w_wq_cnt_nxt[i];
      end
    end
  end

  logic [DATA_WIDTH-1:0] r_mem [NW];
  logic [IW-1:0]         w_wr_addr;
  logic [DATA_WIDTH-1:0] w_rd_word;
  assign w_wr_addr = r_wq_idx[0];

  // Array read with same-edge write forwarding of the unmasked bytes.
  always_comb begin
    w_rd_word = r_mem[w_idx];
    if (w_pop && (w_wr_addr == w_idx)) begin
      for (int b = 0; b < NB; b++) begin
        if (!dfi_wrdata_mask_0_p0[b]) w_rd_word[b*8 +: 8] = dfi_wrdata_0_p0[b*8 +: 8];
      end
    end
  end

  // Word array: cleared by mc_rst only, byte-masked writes on queue pop.
  always_ff @(posedge mck) begin
    if (mc_rst) begin
      for (int i = 0; i < NW; i++) r_mem[i] <= '0;
    end else if (w_pop) begin
      for (int b = 0; b < NB; b++) begin
        if (!dfi_wrdata_mask_0_p0[b]) r_mem[w_wr_addr][b*8 +: 8] <= dfi_wrdata_0_p0[b*8 +: 8];
      end
    end
  end

  logic                  r_rp_vld  [RDLAT];
  logic [DATA_WIDTH-1:0] r_rp_data [RDLAT];
  logic                  r_rd_vld;
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Read latency pipe plus output register: RD on edge T shows on edge T+RDLAT.
  always_ff @(posedge mck) begin
    if (w_rst) begin
      for (int k = 0; k < RDLAT; k++) begin
        r_rp_vld[k]  <= 1'b0;
        r_rp_data[k] <= '0;
      end
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rp_vld[0]  <= w_rd_acc;
      r_rp_data[0] <= w_rd_acc ? w_rd_word : '0;
      for (int k = 1; k < RDLAT; k++) begin
        r_rp_vld[k]  <= r_rp_vld[k-1];
        r_rp_data[k] <= r_rp_data[k-1];
      end
      r_rd_vld  <= r_rp_vld[RDLAT-1];
      r_rd_data <= r_rp_data[RDLAT-1];
    end
  end

  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;
  logic        r_err_proto;
  logic        r_err_wdata;

  // Accepted-command counters and sticky error flags.
  always_ff @(posedge mck) begin
    if (w_rst) begin
      r_rd_count  <= '0;
      r_wr_count  <= '0;
      r_err_proto <= 1'b0;
      r_err_wdata <= 1'b0;
    end else begin
      if (w_rd_acc) r_rd_count <= r_rd_count + 16'd1;
      if (w_wr_acc) r_wr_count <= r_wr_count + 16'd1;
      if (w_proto_bad) r_err_proto <= 1'b1;
      if (w_wr_drop || w_wen_empty || w_wr_off_time) r_err_wdata <= 1'b1;
    end
  end

  assign dfi_rddata_0_p0       = r_rd_data;
  assign dfi_rddata_valid_0_p0 = r_rd_vld;
  assign rank_active           = (r_state == ST_ACTIVE);
  assign err_proto             = r_err_proto;
  assign err_wdata             = r_err_wdata;
  assign rd_count              = r_rd_count;
  assign wr_count              = r_wr_count;

endmodule

// File: tb/tb_openddr_dfi_phy_responder.sv
// Directed bench for openddr_dfi_phy_responder. Instance u_dut uses the
// default parameters; u_dut8 (MEM_DEPTH=8) shares the same inputs and is
// used to observe index wrap-around.
module tb_openddr_dfi_phy_responder;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ACT = 3'b001;
  localparam logic [2:0] OP_WR  = 3'b010;
  localparam logic [2:0] OP_RD  = 3'b011;
  localparam logic [2:0] OP_PRE = 3'b100;
  localparam logic [2:0] OP_REF = 3'b101;
  localparam int RDLAT = 4;

  logic        mck = 1'b0;
  logic        mc_rst = 1'b1;
  logic        dfi_reset_n = 1'b1;
  logic [1:0]  cs = '0;
  logic [6:0]  addr = '0;
  logic [63:0] wdata = '0;
  logic [7:0]  wmask = '0;
  logic        wen = 1'b0;

  logic [63:0] rdata;
  logic        rvalid, rank, errp, errw;
  logic [15:0] rdc, wrc;
  logic [63:0] b_rdata;
  logic        b_rvalid, b_rank, b_errp, b_errw;
  logic [15:0] b_rdc, b_wrc;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;

  logic [63:0] got_a_q[$];
  int          got_a_t[$];
  logic [63:0] got_b_q[$];
  int          got_b_t[$];
  logic [63:0] exp_q[$];

  // clock / reset
  always #5 mck = ~mck;
  always @(posedge mck) cyc_n <= cyc_n + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1);
  end

  openddr_dfi_phy_responder u_dut (
    .mck(mck), .mc_rst(mc_rst), .dfi_reset_n(dfi_reset_n),
    .dfi_cs_0_p0(cs), .dfi_address_0_p0(addr),
    .dfi_wrdata_0_p0(wdata), .dfi_wrdata_mask_0_p0(wmask), .dfi_wrdata_en_0_p0(wen),
    .dfi_rddata_0_p0(rdata), .dfi_rddata_valid_0_p0(rvalid),
    .rank_active(rank), .err_proto(errp), .err_wdata(errw),
    .rd_count(rdc), .wr_count(wrc)
  );

  openddr_dfi_phy_responder #(.MEM_DEPTH(8)) u_dut8 (
    .mck(mck), .mc_rst(mc_rst), .dfi_reset_n(dfi_reset_n),
    .dfi_cs_0_p0(cs), .dfi_address_0_p0(addr),
    .dfi_wrdata_0_p0(wdata), .dfi_wrdata_mask_0_p0(wmask), .dfi_wrdata_en_0_p0(wen),
    .dfi_rddata_0_p0(b_rdata), .dfi_rddata_valid_0_p0(b_rvalid),
    .rank_active(b_rank), .err_proto(b_errp), .err_wdata(b_errw),
    .rd_count(b_rdc), .wr_count(b_wrc)
  );

  // read-data monitor, sampled mid-cycle
  always @(negedge mck) begin
    if (rvalid)   begin got_a_q.push_back(rdata);   got_a_t.push_back(cyc_n); end
    if (b_rvalid) begin got_b_q.push_back(b_rdata); got_b_t.push_back(cyc_n); end
  end

  // driver tasks
  task automatic cyc(input logic c0, input logic [2:0] op, input logic [3:0] idx,
                     input logic en, input logic [63:0] d, input logic [7:0] m);
    cs = {1'b0, c0}; addr = {op, idx}; wen = en; wdata = d; wmask = m;
    @(posedge mck); #1;
    cs = '0; addr = '0; wen = 1'b0; wdata = '0; wmask = '0;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [3:0] idx);
    cyc(1'b1, op, idx, 1'b0, 64'h0, 8'h0);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, OP_NOP, 4'h0, 1'b0, 64'h0, 8'h0);
  endtask

  task automatic wdat(input logic [63:0] d, input logic [7:0] m);
    cyc(1'b0, OP_NOP, 4'h0, 1'b1, d, m);
  endtask

  task automatic do_reset();
    mc_rst = 1'b1; nop(1); mc_rst = 1'b0;
  endtask

  task automatic clear_mon();
    got_a_q.delete(); got_a_t.delete(); got_b_q.delete(); got_b_t.delete();
  endtask

  // single RD: returns number of valids, latency of the first and its data
  task automatic rd_one(input logic [3:0] idx, output int n, output int lat, output logic [63:0] d);
    int t;
    clear_mon();
    cmd(OP_RD, idx);
    t = cyc_n;
    nop(RDLAT + 3);
    n = got_a_q.size();
    lat = (n > 0) ? got_a_t[0] - t : -1;
    d = (n > 0) ? got_a_q[0] : 64'hx;
  endtask

  task automatic test_reset();
    do_reset();
    nop(1);
    n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", rvalid); end
    n_vec++; if (rdata !== 64'h0) begin n_err++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    n_vec++; if (rank !== 1'b0) begin n_err++; $display("FAIL rst_rank got=%b exp=0", rank); end
    n_vec++; if ({errp, errw} !== 2'b00) begin n_err++; $display("FAIL rst_err got=%b exp=00", {errp, errw}); end
    n_vec++; if ({rdc, wrc} !== 32'h0) begin n_err++; $display("FAIL rst_counts got=%h exp=0", {rdc, wrc}); end
  endtask

  task automatic test_write_read();
    int n, lat; logic [63:0] d;
    do_reset();
    cmd(OP_ACT, 4'd0);
    n_vec++; if (rank !== 1'b1) begin n_err++; $display("FAIL wr_rank_after_act got=%b exp=1", rank); end
    cmd(OP_WR, 4'd3);
    nop(1);
    wdat(64'h1122334455667788, 8'h00);
    rd_one(4'd3, n, lat, d);
    n_vec++; if (n !== 1) begin n_err++; $display("FAIL wr_valid_count got=%0d exp=1", n); end
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL wr_rd_latency got=%0d exp=4", lat); end
    n_vec++; if (d !== 64'h1122334455667788) begin n_err++; $display("FAIL wr_rd_data got=%h exp=1122334455667788", d); end
    n_vec++; if (wrc !== 16'd1 || rdc !== 16'd1) begin n_err++; $display("FAIL wr_counts got wr=%0d rd=%0d exp 1/1", wrc, rdc); end
    n_vec++; if ({errp, errw} !== 2'b00) begin n_err++; $display("FAIL wr_no_err got=%b exp=00", {errp, errw}); end
  endtask

  task automatic test_masked_write();
    int n, lat; logic [63:0] d;
    cmd(OP_WR, 4'd5); nop(1); wdat(64'hFFFFFFFFFFFFFFFF, 8'h00);
    cmd(OP_WR, 4'd5); nop(1); wdat(64'h0, 8'h0F);
    rd_one(4'd5, n, lat, d);
    n_vec++; if (n !== 1 || lat !== 4) begin n_err++; $display("FAIL mask_timing got n=%0d lat=%0d exp 1/4", n, lat); end
    n_vec++; if (d !== 64'h00000000FFFFFFFF) begin n_err++; $display("FAIL mask_data got=%h exp=00000000ffffffff", d); end
    n_vec++; if (wrc !== 16'd3 || rdc !== 16'd2) begin n_err++; $display("FAIL mask_counts got wr=%0d rd=%0d exp 3/2", wrc, rdc); end
  endtask

  task automatic test_proto();
    int n, lat; logic [63:0] d;
    do_reset();
    rd_one(4'd0, n, lat, d);
    n_vec++; if (n !== 0) begin n_err++; $display("FAIL proto_idle_rd_valid got=%0d exp=0", n); end
    n_vec++; if (errp !== 1'b1) begin n_err++; $display("FAIL proto_idle_rd_err got=%b exp=1", errp); end
    n_vec++; if (rdc !== 16'd0) begin n_err++; $display("FAIL proto_idle_rd_count got=%0d exp=0", rdc); end
    do_reset();
    cmd(OP_REF, 4'd0); cmd(OP_PRE, 4'd0);
    cs = 2'b10; addr = {OP_RD, 4'd0}; @(posedge mck); #1; cs = '0; addr = '0;
    n_vec++; if (errp !== 1'b0 || rank !== 1'b0) begin n_err++; $display("FAIL proto_legal_idle got err=%b rank=%b exp 0/0", errp, rank); end
    cmd(OP_ACT, 4'd0);
    n_vec++; if (errp !== 1'b0 || rank !== 1'b1) begin n_err++; $display("FAIL proto_act got err=%b rank=%b exp 0/1", errp, rank); end
    cmd(OP_ACT, 4'd0);
    n_vec++; if (errp !== 1'b1 || rank !== 1'b1) begin n_err++; $display("FAIL proto_act_act got err=%b rank=%b exp 1/1", errp, rank); end
    cmd(OP_PRE, 4'd0);
    n_vec++; if (errp !== 1'b1 || rank !== 1'b0) begin n_err++; $display("FAIL proto_sticky_pre got err=%b rank=%b exp 1/0", errp, rank); end
    do_reset();
    cmd(OP_ACT, 4'd0);
    cmd(3'b110, 4'd0);
    n_vec++; if (errp !== 1'b1 || rank !== 1'b1) begin n_err++; $display("FAIL proto_bad_opcode got err=%b rank=%b exp 1/1", errp, rank); end
  endtask

  task automatic test_wdata_errors();
    int n, lat; logic [63:0] d;
    do_reset();
    cmd(OP_ACT, 4'd0);
    for (int i = 0; i < 4; i++) cmd(OP_WR, 4'(i));
    n_vec++; if (errw !== 1'b0 || wrc !== 16'd4) begin n_err++; $display("FAIL wq_four got err=%b wr=%0d exp 0/4", errw, wrc); end
    cmd(OP_WR, 4'd4);
    n_vec++; if (errw !== 1'b1 || wrc !== 16'd4) begin n_err++; $display("FAIL wq_full got err=%b wr=%0d exp 1/4", errw, wrc); end
    do_reset();
    wdat(64'h1234, 8'h00);
    n_vec++; if (errw !== 1'b1) begin n_err++; $display("FAIL wq_empty_en got=%b exp=1", errw); end
    do_reset();
    cmd(OP_ACT, 4'd0);
    cmd(OP_WR, 4'd2);
    wdat(64'hA5A5A5A5A5A5A5A5, 8'h00);
    n_vec++; if (errw !== 1'b1) begin n_err++; $display("FAIL wq_early_err got=%b exp=1", errw); end
    rd_one(4'd2, n, lat, d);
    n_vec++; if (n !== 1 || d !== 64'hA5A5A5A5A5A5A5A5) begin n_err++; $display("FAIL wq_early_data got n=%0d d=%h exp 1/a5a5a5a5a5a5a5a5", n, d); end
    dfi_reset_n = 1'b0; nop(1); dfi_reset_n = 1'b1;
    n_vec++; if ({rank, errp, errw} !== 3'b000 || {rdc, wrc} !== 32'h0) begin n_err++; $display("FAIL dfirst_state got=%b/%h exp 000/0", {rank, errp, errw}, {rdc, wrc}); end
    cmd(OP_ACT, 4'd0);
    rd_one(4'd2, n, lat, d);
    n_vec++; if (n !== 1 || d !== 64'hA5A5A5A5A5A5A5A5) begin n_err++; $display("FAIL dfirst_keeps_array got n=%0d d=%h exp 1/a5a5a5a5a5a5a5a5", n, d); end
    do_reset();
    cmd(OP_ACT, 4'd0);
    rd_one(4'd2, n, lat, d);
    n_vec++; if (n !== 1 || d !== 64'h0) begin n_err++; $display("FAIL mcrst_clears_array got n=%0d d=%h exp 1/0", n, d); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] bb [4];
    logic [63:0] g, e;
    int t0, t, sz;
    bb[0] = 64'hDEADBEEF00000000; bb[1] = 64'h0123456789ABCDEF;
    bb[2] = 64'hFFFF0000FFFF0000; bb[3] = 64'h8000000000000001;
    do_reset();
    cmd(OP_ACT, 4'd0);
    cyc(1'b1, OP_WR, 4'd0, 1'b0, 64'h0, 8'h00);
    cyc(1'b1, OP_WR, 4'd1, 1'b0, 64'h0, 8'h00);
    cyc(1'b1, OP_WR, 4'd2, 1'b1, bb[0], 8'h00);
    cyc(1'b1, OP_WR, 4'd3, 1'b1, bb[1], 8'h00);
    wdat(bb[2], 8'h00);
    wdat(bb[3], 8'h00);
    n_vec++; if (errw !== 1'b0) begin n_err++; $display("FAIL b2b_wr_err got=%b exp=0", errw); end
    clear_mon();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(bb[i]);
    cmd(OP_RD, 4'd0);
    t0 = cyc_n;
    cmd(OP_RD, 4'd1); cmd(OP_RD, 4'd2); cmd(OP_RD, 4'd3);
    nop(RDLAT + 3);
    sz = got_a_q.size();
    n_vec++; if (sz !== 4) begin n_err++; $display("FAIL b2b_count got=%0d exp=4", sz); end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      g = (got_a_q.size() > 0) ? got_a_q.pop_front() : 64'hx;
      t = (got_a_t.size() > 0) ? got_a_t.pop_front() : -1;
      n_vec++; if (g !== e || t !== t0 + RDLAT + i) begin n_err++; $display("FAIL b2b_rd%0d got d=%h t=%0d exp d=%h t=%0d", i, g, t, e, t0 + RDLAT + i); end
    end
    clear_mon();
    cmd(OP_RD, 4'd0); cmd(OP_RD, 4'd1);
    mc_rst = 1'b1; nop(1); mc_rst = 1'b0;
    nop(RDLAT + 4);
    sz = got_a_q.size();
    n_vec++; if (sz !== 0) begin n_err++; $display("FAIL b2b_rst_valids got=%0d exp=0", sz); end
    n_vec++; if ({rvalid, rank, errp, errw} !== 4'b0000 || rdata !== 64'h0 || {rdc, wrc} !== 32'h0) begin
      n_err++; $display("FAIL b2b_rst_outputs got=%b/%h/%h exp 0000/0/0", {rvalid, rank, errp, errw}, rdata, {rdc, wrc}); end
  endtask

  task automatic test_forward();
    int sz, t, tg; logic [63:0] g;
    do_reset();
    cmd(OP_ACT, 4'd0);
    cmd(OP_WR, 4'd7); nop(1);
    clear_mon();
    cyc(1'b1, OP_RD, 4'd7, 1'b1, 64'hCAFEF00D12345678, 8'h00);
    t = cyc_n;
    nop(RDLAT + 3);
    sz = got_a_q.size(); g = (sz > 0) ? got_a_q[0] : 64'hx; tg = (sz > 0) ? got_a_t[0] : -1;
    n_vec++; if (sz !== 1 || tg !== t + RDLAT) begin n_err++; $display("FAIL fwd_timing got n=%0d t=%0d exp 1/%0d", sz, tg, t + RDLAT); end
    n_vec++; if (g !== 64'hCAFEF00D12345678) begin n_err++; $display("FAIL fwd_full got=%h exp=cafef00d12345678", g); end
    cmd(OP_WR, 4'd7); nop(1);
    clear_mon();
    cyc(1'b1, OP_RD, 4'd7, 1'b1, 64'h0, 8'hF0);
    nop(RDLAT + 3);
    sz = got_a_q.size(); g = (sz > 0) ? got_a_q[0] : 64'hx;
    n_vec++; if (sz !== 1 || g !== 64'hCAFEF00D00000000) begin n_err++; $display("FAIL fwd_masked got n=%0d d=%h exp 1/cafef00d00000000", sz, g); end
    n_vec++; if (errw !== 1'b0) begin n_err++; $display("FAIL fwd_err got=%b exp=0", errw); end
  endtask

  task automatic test_alias();
    logic [63:0] g, e;
    int t0, t, sza, szb;
    do_reset();
    cmd(OP_ACT, 4'd0);
    for (int i = 0; i < 10; i++)
      cyc(i < 8, OP_WR, 4'(8 + i), i >= 2, (i >= 2) ? 64'(i - 1) * 64'h1111111111111111 : 64'h0, 8'h00);
    clear_mon();
    cmd(OP_RD, 4'd0);
    t0 = cyc_n;
    for (int i = 1; i < 8; i++) cmd(OP_RD, 4'(i));
    nop(RDLAT + 3);
    sza = got_a_q.size(); szb = got_b_q.size();
    n_vec++; if (sza !== 8 || szb !== 8) begin n_err++; $display("FAIL alias_counts got a=%0d b=%0d exp 8/8", sza, szb); end
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(64'(i + 1) * 64'h1111111111111111);
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      g = (got_b_q.size() > 0) ? got_b_q.pop_front() : 64'hx;
      t = (got_b_t.size() > 0) ? got_b_t.pop_front() : -1;
      n_vec++; if (g !== e || t !== t0 + RDLAT + i) begin n_err++; $display("FAIL alias_d8_rd%0d got d=%h t=%0d exp d=%h t=%0d", i, g, t, e, t0 + RDLAT + i); end
    end
    for (int i = 0; i < 8; i++) begin
      g = (got_a_q.size() > 0) ? got_a_q.pop_front() : 64'hx;
      n_vec++; if (g !== 64'h0) begin n_err++; $display("FAIL alias_d16_rd%0d got=%h exp=0", i, g); end
    end
    n_vec++; if (b_wrc !== 16'd8 || b_rdc !== 16'd8) begin n_err++; $display("FAIL alias_d8_counts got wr=%0d rd=%0d exp 8/8", b_wrc, b_rdc); end
    n_vec++; if ({b_rank, b_errp, b_errw, errw} !== 4'b1000) begin n_err++; $display("FAIL alias_flags got=%b exp=1000", {b_rank, b_errp, b_errw, errw}); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_masked_write();
    test_proto();
    test_wdata_errors();
    test_back_to_back();
    test_forward();
    test_alias();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
